// File: rtl/packetparse_conv.sv
// UDP/IPv4 receive converter: strips the pad+Ethernet+IPv4+UDP header from a framed packet,
// filters on address/port/checksum and streams the UDP payload to a downstream FIFO.
module packetparse_conv #(
  parameter bit ACCEPT_BCAST  = 1'b1,
  parameter bit CHECK_IP_CSUM = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [47:0] my_mac,
  input  logic [31:0] my_ip,
  input  logic [15:0] my_port,
  input  logic        in_packet_trig,
  input  logic [31:0] in_packet_len,
  input  logic [31:0] in_packet_data,
  output logic        in_packet_rden,
  output logic [31:0] out_payload_data,
  output logic        out_payload_we,
  input  logic        out_payload_full,
  output logic [15:0] out_payload_len,
  output logic [47:0] out_src_mac,
  output logic [31:0] out_src_ip,
  output logic [15:0] out_src_port,
  output logic        out_payload_done,
  output logic        out_drop,
  output logic [15:0] rx_ok_cnt,
  output logic [15:0] rx_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_CHECK,
    S_DATA,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t      state;
  logic [15:0] wcnt;
  logic [15:0] pcnt;
  logic [47:0] dmac;
  logic [47:0] smac;
  logic [15:0] etype;
  logic [7:0]  verihl;
  logic [7:0]  proto;
  logic [31:0] sip;
  logic [31:0] dip;
  logic [15:0] sport;
  logic [15:0] dport;
  logic [15:0] udp_len;
  logic [31:0] csum_acc;
  logic        ok_flag;

  // Header fields are big-endian on the wire, the first wire byte sits in lane 0.
  logic [31:0] w;
  assign w = {in_packet_data[7:0], in_packet_data[15:8],
              in_packet_data[23:16], in_packet_data[31:24]};

  logic [30:0] total_words;
  assign total_words = {1'b0, in_packet_len[31:2]} + {30'b0, |in_packet_len[1:0]};

  logic [15:0] pay_bytes;
  logic [14:0] pay_words;
  assign pay_bytes = udp_len - 16'd8;
  assign pay_words = {1'b0, pay_bytes[15:2]} + {14'b0, |pay_bytes[1:0]};

  logic [30:0] data_end;
  assign data_end = 31'd11 + {16'b0, pay_words};

  logic [16:0] fold1;
  logic [15:0] fold2;
  assign fold1 = {1'b0, csum_acc[31:16]} + {1'b0, csum_acc[15:0]};
  assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

  logic dmac_ok;
  logic csum_ok;
  logic len_ok;
  logic accept;
  assign dmac_ok = (dmac == my_mac) || (ACCEPT_BCAST && (dmac == 48'hffff_ffff_ffff));
  assign csum_ok = !CHECK_IP_CSUM || (fold2 == 16'hffff);
  assign len_ok  = (udp_len >= 16'd8) && ({16'b0, udp_len} <= (in_packet_len - 32'd36));
  assign accept  = (etype == 16'h0800) && (verihl == 8'h45) && (proto == 8'h11) &&
                   dmac_ok && (dip == my_ip) && (dport == my_port) && len_ok && csum_ok;

  // Payload words go straight from the upstream FIFO to the payload FIFO with no latency.
  assign in_packet_rden   = (state == S_HEADER) || (state == S_DRAIN) ||
                            ((state == S_DATA) && !out_payload_full);
  assign out_payload_we   = (state == S_DATA) && !out_payload_full;
  assign out_payload_data = (state == S_DATA) ? in_packet_data : 32'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= S_IDLE;
      wcnt             <= 16'd0;
      pcnt             <= 16'd0;
      dmac             <= 48'd0;
      smac             <= 48'd0;
      etype            <= 16'd0;
      verihl           <= 8'd0;
      proto            <= 8'd0;
      sip              <= 32'd0;
      dip              <= 32'd0;
      sport            <= 16'd0;
      dport            <= 16'd0;
      udp_len          <= 16'd0;
      csum_acc         <= 32'd0;
      ok_flag          <= 1'b0;
      out_payload_len  <= 16'd0;
      out_src_mac      <= 48'd0;
      out_src_ip       <= 32'd0;
      out_src_port     <= 16'd0;
      out_payload_done <= 1'b0;
      out_drop         <= 1'b0;
      rx_ok_cnt        <= 16'd0;
      rx_drop_cnt      <= 16'd0;
    end else begin
      out_payload_done <= 1'b0;
      out_drop         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_packet_trig) begin
            wcnt     <= 16'd0;
            csum_acc <= 32'd0;
            ok_flag  <= 1'b0;
            if (in_packet_len >= 32'd44)
              state <= S_HEADER;
            else if (total_words == 31'd0)
              state <= S_FIN;
            else
              state <= S_DRAIN;
          end
        end
        S_HEADER: begin
          wcnt <= wcnt + 16'd1;
          case (wcnt)
            16'd0:  dmac[47:32] <= w[15:0];
            16'd1:  dmac[31:0]  <= w;
            16'd2:  smac[47:16] <= w;
            16'd3:  begin smac[15:0] <= w[31:16]; etype <= w[15:0]; end
            16'd4:  verihl <= w[31:24];
            16'd6:  proto <= w[23:16];
            16'd7:  sip <= w;
            16'd8:  dip <= w;
            16'd9:  begin sport <= w[31:16]; dport <= w[15:0]; end
            16'd10: udp_len <= w[31:16];
            default: ;
          endcase
          if ((wcnt >= 16'd4) && (wcnt <= 16'd8))
            csum_acc <= csum_acc + {16'b0, w[31:16]} + {16'b0, w[15:0]};
          if (wcnt == 16'd10)
            state <= S_CHECK;
        end
        S_CHECK: begin
          pcnt <= 16'd0;
          if (accept) begin
            ok_flag         <= 1'b1;
            out_src_mac     <= smac;
            out_src_ip      <= sip;
            out_src_port    <= sport;
            out_payload_len <= pay_bytes;
            // An empty payload still has to consume any Ethernet pad behind the header.
            if (pay_words != 15'd0)
              state <= S_DATA;
            else if (total_words > 31'd11)
              state <= S_DRAIN;
            else
              state <= S_FIN;
          end else begin
            ok_flag <= 1'b0;
            state   <= (total_words == 31'd11) ? S_FIN : S_DRAIN;
          end
        end
        S_DATA: begin
          if (!out_payload_full) begin
            wcnt <= wcnt + 16'd1;
            pcnt <= pcnt + 16'd1;
            if (pcnt == ({1'b0, pay_words} - 16'd1))
              state <= (total_words > data_end) ? S_DRAIN : S_FIN;
          end
        end
        S_DRAIN: begin
          wcnt <= wcnt + 16'd1;
          if (({15'b0, wcnt} + 31'd1) >= total_words)
            state <= S_FIN;
        end
        S_FIN: begin
          if (ok_flag) begin
            out_payload_done <= 1'b1;
            rx_ok_cnt        <= rx_ok_cnt + 16'd1;
          end else begin
            out_drop    <= 1'b1;
            rx_drop_cnt <= rx_drop_cnt + 16'd1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packetparse_conv.sv
// Self-checking bench for packetparse_conv: directed vector table, reset-abort sequence and
// randomized frames checked against a field-level reference model.
module tb_packetparse_conv;

  localparam logic [47:0] MY_MAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] MY_IP   = 32'hc0a8_0164;
  localparam logic [15:0] MY_PORT = 16'd5000;

  typedef struct {
    string       name;
    int          len;
    logic [15:0] udp_len;
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [15:0] dport;
    logic [15:0] etype;
    logic [7:0]  verihl;
    logic [7:0]  proto;
    bit          bad_csum;
    int          full_mode;
    int          pl_base;
    bit          exp_ok;
    int          exp_writes;
    int          exp_rden;
    bit          exp_ok_nc;
    bit          exp_ok_nb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_packet_trig = 1'b0;
  logic [31:0] in_packet_len = 32'd0;
  logic [31:0] in_packet_data;
  logic        out_payload_full = 1'b0;

  logic        rden, we, done, drop;
  logic [31:0] pdata, src_ip;
  logic [15:0] plen, src_port, ok_cnt, drop_cnt;
  logic [47:0] src_mac;

  logic        rden_nc, we_nc, done_nc, drop_nc;
  logic [31:0] pdata_nc, src_ip_nc;
  logic [15:0] plen_nc, src_port_nc, ok_cnt_nc, drop_cnt_nc;
  logic [47:0] src_mac_nc;

  logic        rden_nb, we_nb, done_nb, drop_nb;
  logic [31:0] pdata_nb, src_ip_nb;
  logic [15:0] plen_nb, src_port_nb, ok_cnt_nb, drop_cnt_nb;
  logic [47:0] src_mac_nb;

  always #5 clk = ~clk;

  packetparse_conv #(.ACCEPT_BCAST(1'b1), .CHECK_IP_CSUM(1'b1)) dut (
    .clk(clk), .rstn(rstn), .my_mac(MY_MAC), .my_ip(MY_IP), .my_port(MY_PORT),
    .in_packet_trig(in_packet_trig), .in_packet_len(in_packet_len),
    .in_packet_data(in_packet_data), .in_packet_rden(rden),
    .out_payload_data(pdata), .out_payload_we(we), .out_payload_full(out_payload_full),
    .out_payload_len(plen), .out_src_mac(src_mac), .out_src_ip(src_ip),
    .out_src_port(src_port), .out_payload_done(done), .out_drop(drop),
    .rx_ok_cnt(ok_cnt), .rx_drop_cnt(drop_cnt));

  packetparse_conv #(.ACCEPT_BCAST(1'b1), .CHECK_IP_CSUM(1'b0)) dut_nc (
    .clk(clk), .rstn(rstn), .my_mac(MY_MAC), .my_ip(MY_IP), .my_port(MY_PORT),
    .in_packet_trig(in_packet_trig), .in_packet_len(in_packet_len),
    .in_packet_data(in_packet_data), .in_packet_rden(rden_nc),
    .out_payload_data(pdata_nc), .out_payload_we(we_nc), .out_payload_full(out_payload_full),
    .out_payload_len(plen_nc), .out_src_mac(src_mac_nc), .out_src_ip(src_ip_nc),
    .out_src_port(src_port_nc), .out_payload_done(done_nc), .out_drop(drop_nc),
    .rx_ok_cnt(ok_cnt_nc), .rx_drop_cnt(drop_cnt_nc));

  packetparse_conv #(.ACCEPT_BCAST(1'b0), .CHECK_IP_CSUM(1'b1)) dut_nb (
    .clk(clk), .rstn(rstn), .my_mac(MY_MAC), .my_ip(MY_IP), .my_port(MY_PORT),
    .in_packet_trig(in_packet_trig), .in_packet_len(in_packet_len),
    .in_packet_data(in_packet_data), .in_packet_rden(rden_nb),
    .out_payload_data(pdata_nb), .out_payload_we(we_nb), .out_payload_full(out_payload_full),
    .out_payload_len(plen_nb), .out_src_mac(src_mac_nb), .out_src_ip(src_ip_nb),
    .out_src_port(src_port_nb), .out_payload_done(done_nb), .out_drop(drop_nb),
    .rx_ok_cnt(ok_cnt_nb), .rx_drop_cnt(drop_cnt_nb));

  // Upstream FWFT FIFO model: frame bytes in mem, read pointer driven by the main DUT.
  logic [7:0] mem [0:4095];
  int unsigned rd_ptr = 0;
  int unsigned base = 0;
  int widx;

  always @(posedge clk) if (rden) rd_ptr <= rd_ptr + 1;

  always_comb begin
    widx = int'(rd_ptr - base);
    in_packet_data = 32'heeee_eeee;
    for (int k = 0; k < 4; k++)
      if (widx * 4 + k < 4096 && widx >= 0) in_packet_data[8*k +: 8] = mem[widx * 4 + k];
  end

  int full_mode = 0;
  always @(posedge clk) begin
    #1;
    case (full_mode)
      0: out_payload_full = 1'b0;
      1: out_payload_full = ~out_payload_full;
      2: out_payload_full = 1'($urandom_range(0, 1));
      default: out_payload_full = 1'b1;
    endcase
  end

  // Output monitor, sampled on the falling edge.
  logic [31:0] got[$];
  int rd_count, wf_err, ok_seen, drop_seen, ok_nc_seen, drop_nc_seen, ok_nb_seen, drop_nb_seen;
  always @(negedge clk) begin
    if (rden) rd_count++;
    if (we) begin
      got.push_back(pdata);
      if (out_payload_full) wf_err++;
    end
    if (done) ok_seen++;
    if (drop) drop_seen++;
    if (done_nc) ok_nc_seen++;
    if (drop_nc) drop_nc_seen++;
    if (done_nb) ok_nb_seen++;
    if (drop_nb) drop_nb_seen++;
  end

  int errors = 0;
  int checks = 0;
  int exp_ok_cnt = 0, exp_drop_cnt = 0, exp_ok_nc = 0, exp_drop_nc = 0, exp_ok_nb = 0, exp_drop_nb = 0;
  logic [47:0] last_smac = '0;
  logic [31:0] last_sip = '0;
  logic [15:0] last_sport = '0;
  logic [15:0] last_plen = '0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic bit model_accept(input vec_t v, input bit ab, input bit cc);
    bit dm;
    dm = (v.dmac == MY_MAC) || (ab && v.dmac == 48'hffff_ffff_ffff);
    return (v.len >= 44) && (v.etype == 16'h0800) && (v.verihl == 8'h45) && (v.proto == 8'h11) &&
           dm && (v.dip == MY_IP) && (v.dport == MY_PORT) && (v.udp_len >= 8) &&
           (int'(v.udp_len) <= v.len - 36) && (!cc || !v.bad_csum);
  endfunction

  function automatic vec_t good_vec(input string name, input int len, input int udp);
    vec_t v;
    v.name = name; v.len = len; v.udp_len = 16'(udp);
    v.dmac = MY_MAC; v.dip = MY_IP; v.dport = MY_PORT;
    v.etype = 16'h0800; v.verihl = 8'h45; v.proto = 8'h11;
    v.bad_csum = 0; v.full_mode = 0; v.pl_base = 1;
    v.exp_ok = 0; v.exp_writes = 0; v.exp_rden = 0; v.exp_ok_nc = 0; v.exp_ok_nb = 0;
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t vi, input bit ok, input int wr, input int rd,
                                    input bit ok_nc, input bit ok_nb);
    vec_t v;
    v = vi;
    v.exp_ok = ok; v.exp_writes = wr; v.exp_rden = rd; v.exp_ok_nc = ok_nc; v.exp_ok_nb = ok_nb;
    return v;
  endfunction

  task automatic put_be(input int off, input logic [63:0] val, input int n);
    for (int i = 0; i < n; i++) mem[off + i] = val[8*(n-1-i) +: 8];
  endtask

  task automatic build_frame(input vec_t v, output logic [47:0] smac, output logic [31:0] sip,
                             output logic [15:0] sport);
    int sum;
    logic [15:0] c;
    smac  = {16'($urandom), 32'($urandom)};
    sip   = 32'($urandom);
    sport = 16'($urandom);
    for (int i = 0; i < v.len + 16 && i < 4096; i++) mem[i] = 8'($urandom);
    put_be(0, 64'd0, 2);
    put_be(2, 64'(v.dmac), 6);
    put_be(8, 64'(smac), 6);
    put_be(14, 64'(v.etype), 2);
    put_be(16, 64'(v.verihl), 1);
    put_be(17, 64'd0, 1);
    put_be(18, 64'(16'd20 + v.udp_len), 2);
    put_be(20, 64'($urandom_range(0, 65535)), 2);
    put_be(22, 64'h4000, 2);
    put_be(24, 64'd64, 1);
    put_be(25, 64'(v.proto), 1);
    put_be(26, 64'd0, 2);
    put_be(28, 64'(sip), 4);
    put_be(32, 64'(v.dip), 4);
    put_be(36, 64'(sport), 2);
    put_be(38, 64'(v.dport), 2);
    put_be(40, 64'(v.udp_len), 2);
    put_be(42, 64'd0, 2);
    for (int i = 44; i < v.len; i++) mem[i] = 8'(v.pl_base + i - 44);
    sum = 0;
    for (int j = 0; j < 10; j++) sum += {mem[16 + 2*j], mem[17 + 2*j]};
    while (sum > 16'hffff) sum = (sum & 16'hffff) + (sum >> 16);
    c = ~16'(sum);
    if (v.bad_csum) c = c + 16'd1;
    put_be(26, 64'(c), 2);
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [47:0] smac;
    logic [31:0] sip;
    logic [15:0] sport;
    bit finished;
    int pl, nw;
    logic [31:0] mask, expw;
    build_frame(v, smac, sip, sport);
    in_packet_len = 32'(v.len);
    base = rd_ptr;
    got.delete();
    rd_count = 0; wf_err = 0;
    ok_seen = 0; drop_seen = 0; ok_nc_seen = 0; drop_nc_seen = 0; ok_nb_seen = 0; drop_nb_seen = 0;
    full_mode = v.full_mode;
    @(posedge clk); #1 in_packet_trig = 1'b1;
    @(posedge clk); #1 in_packet_trig = 1'b0;
    finished = 0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(posedge clk); #1;
      finished = (ok_seen + drop_seen >= 1) && (ok_nc_seen + drop_nc_seen >= 1) &&
                 (ok_nb_seen + drop_nb_seen >= 1);
    end
    full_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    check_output({v.name, ".finished"}, 64'(finished), 64'd1);
    check_output({v.name, ".done"}, 64'(ok_seen), 64'(v.exp_ok));
    check_output({v.name, ".drop"}, 64'(drop_seen), 64'(!v.exp_ok));
    check_output({v.name, ".rden"}, 64'(rd_count), 64'(v.exp_rden));
    check_output({v.name, ".writes"}, 64'(got.size()), 64'(v.exp_writes));
    check_output({v.name, ".we_full"}, 64'(wf_err), 64'd0);
    pl = int'(v.udp_len) - 8;
    nw = (got.size() < v.exp_writes) ? got.size() : v.exp_writes;
    for (int i = 0; i < nw; i++) begin
      mask = '0; expw = '0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < pl) begin
          mask[8*k +: 8] = 8'hff;
          expw[8*k +: 8] = mem[44 + 4*i + k];
        end
      check_output($sformatf("%s.data%0d", v.name, i), 64'(got[i] & mask), 64'(expw));
    end
    if (v.exp_ok) begin
      exp_ok_cnt++;
      last_smac = smac; last_sip = sip; last_sport = sport; last_plen = 16'(pl);
    end else exp_drop_cnt++;
    if (v.exp_ok_nc) exp_ok_nc++; else exp_drop_nc++;
    if (v.exp_ok_nb) exp_ok_nb++; else exp_drop_nb++;
    check_output({v.name, ".len"}, 64'(plen), 64'(last_plen));
    check_output({v.name, ".src_mac"}, 64'(src_mac), 64'(last_smac));
    check_output({v.name, ".src_ip"}, 64'(src_ip), 64'(last_sip));
    check_output({v.name, ".src_port"}, 64'(src_port), 64'(last_sport));
    check_output({v.name, ".ok_cnt"}, 64'(ok_cnt), 64'(exp_ok_cnt & 16'hffff));
    check_output({v.name, ".drop_cnt"}, 64'(drop_cnt), 64'(exp_drop_cnt & 16'hffff));
    check_output({v.name, ".nc_ok_cnt"}, 64'(ok_cnt_nc), 64'(exp_ok_nc & 16'hffff));
    check_output({v.name, ".nc_drop_cnt"}, 64'(drop_cnt_nc), 64'(exp_drop_nc & 16'hffff));
    check_output({v.name, ".nb_ok_cnt"}, 64'(ok_cnt_nb), 64'(exp_ok_nb & 16'hffff));
    check_output({v.name, ".nb_drop_cnt"}, 64'(drop_cnt_nb), 64'(exp_drop_nb & 16'hffff));
  endtask

  task automatic check_idle_outputs(input string name);
    check_output({name, ".rden"}, 64'(rden), 64'd0);
    check_output({name, ".we"}, 64'(we), 64'd0);
    check_output({name, ".data"}, 64'(pdata), 64'd0);
    check_output({name, ".pulses"}, 64'({done, drop}), 64'd0);
    check_output({name, ".len"}, 64'(plen), 64'd0);
    check_output({name, ".src"}, 64'(src_mac) | 64'(src_ip) | 64'(src_port), 64'd0);
    check_output({name, ".cnts"}, 64'({ok_cnt, drop_cnt}), 64'd0);
  endtask

  vec_t vecs[$];
  vec_t v;
  int sel, pl, pad;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    @(posedge clk); #1 rstn = 1'b1;

    vecs.push_back(with_exp(good_vec("valid8", 52, 16), 1, 2, 13, 1, 1));
    vecs.push_back(with_exp(good_vec("pay5_pad", 64, 13), 1, 2, 16, 1, 1));
    v = good_vec("bad_dport", 64, 13); v.dport = MY_PORT + 16'd1;
    vecs.push_back(with_exp(v, 0, 0, 16, 0, 0));
    v = good_vec("bad_dip", 64, 13); v.dip = MY_IP ^ 32'h1;
    vecs.push_back(with_exp(v, 0, 0, 16, 0, 0));
    v = good_vec("bad_dmac", 64, 13); v.dmac = MY_MAC + 48'd1;
    vecs.push_back(with_exp(v, 0, 0, 16, 0, 0));
    v = good_vec("bad_csum", 52, 16); v.bad_csum = 1;
    vecs.push_back(with_exp(v, 0, 0, 13, 1, 0));
    v = good_vec("bcast", 52, 16); v.dmac = 48'hffff_ffff_ffff;
    vecs.push_back(with_exp(v, 1, 2, 13, 1, 0));
    v = good_vec("full_toggle", 108, 72); v.full_mode = 1; v.pl_base = 8'h40;
    vecs.push_back(with_exp(v, 1, 16, 27, 1, 1));
    vecs.push_back(with_exp(good_vec("short40", 40, 8), 0, 0, 10, 0, 0));
    v = good_vec("bad_etype", 52, 16); v.etype = 16'h86dd;
    vecs.push_back(with_exp(v, 0, 0, 13, 0, 0));
    v = good_vec("bad_proto", 52, 16); v.proto = 8'h06;
    vecs.push_back(with_exp(v, 0, 0, 13, 0, 0));
    v = good_vec("bad_verihl", 52, 16); v.verihl = 8'h46;
    vecs.push_back(with_exp(v, 0, 0, 13, 0, 0));
    vecs.push_back(with_exp(good_vec("udp7", 52, 7), 0, 0, 13, 0, 0));
    vecs.push_back(with_exp(good_vec("udp_over", 52, 17), 0, 0, 13, 0, 0));
    vecs.push_back(with_exp(good_vec("udp_edge", 53, 17), 1, 3, 14, 1, 1));
    vecs.push_back(with_exp(good_vec("empty_pay", 44, 8), 1, 0, 11, 1, 1));
    vecs.push_back(with_exp(good_vec("short43", 43, 8), 0, 0, 11, 0, 0));
    vecs.push_back(with_exp(good_vec("len0", 0, 8), 0, 0, 0, 0, 0));

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Reset while stalled in the payload phase, then a clean frame from zeroed counters.
    v = good_vec("abort", 108, 72);
    build_frame(v, last_smac, last_sip, last_sport);
    in_packet_len = 32'd108;
    base = rd_ptr;
    full_mode = 3;
    @(posedge clk); #1 in_packet_trig = 1'b1;
    @(posedge clk); #1 in_packet_trig = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check_output("abort.stalled_we", 64'(we), 64'd0);
    check_output("abort.in_data", 64'(pdata), 64'(in_packet_data));
    rstn = 1'b0;
    #1;
    check_idle_outputs("abort_reset");
    full_mode = 0;
    exp_ok_cnt = 0; exp_drop_cnt = 0; exp_ok_nc = 0; exp_drop_nc = 0; exp_ok_nb = 0; exp_drop_nb = 0;
    last_smac = '0; last_sip = '0; last_sport = '0; last_plen = '0;
    @(posedge clk); #1 rstn = 1'b1;
    apply_stimulus(with_exp(good_vec("after_reset", 52, 16), 1, 2, 13, 1, 1));

    for (int n = 0; n < 40; n++) begin
      pl  = $urandom_range(1, 40);
      pad = $urandom_range(0, 9);
      v = good_vec($sformatf("rand%0d", n), 44 + pl + pad, pl + 8);
      v.pl_base = $urandom_range(0, 255);
      v.full_mode = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      case (sel)
        0: v.dport = 16'($urandom);
        1: v.dip = 32'($urandom);
        2: v.dmac = 48'h0a_00_00_00_00_01;
        3: v.bad_csum = 1;
        4: v.dmac = 48'hffff_ffff_ffff;
        5: v.udp_len = 16'(v.len - 35);
        default: ;
      endcase
      v.exp_ok    = model_accept(v, 1, 1);
      v.exp_ok_nc = model_accept(v, 1, 0);
      v.exp_ok_nb = model_accept(v, 0, 1);
      v.exp_writes = v.exp_ok ? (int'(v.udp_len) - 8 + 3) / 4 : 0;
      v.exp_rden   = (v.len + 3) / 4;
      apply_stimulus(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
